counter_sched: RTL and testbench

//   Shares one up-counter (counter_if DUT side, WIDTH bits) between N_REQ requesters.

---
 rtl/counter_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/counter_sched.sv | 130 +++++++++++++
 tb/tb_counter_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter scheduler.
package counter_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after a rotating
// pointer. The pointer moves to one past the winner when advance is high.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic [IDW-1:0] ptr;

    // Scan from the pointer, wrapping, and take the first active request.
    always_comb begin : pick
        int             cand_int;
        logic [IDW-1:0] cand;
        logic           found;
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand_int = (int'(ptr) + k) % N;
            cand     = IDW'(cand_int);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt_idx      = cand;
                gnt[cand]    = 1'b1;
            end
        end
    end

    // Rotate the pointer past the winner when a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shares one up-counter between N_REQ requesters. A granted requester's start
// value is loaded, the counter runs until it wraps to zero, and the
// requester's done bit pulses.
//
// Handshake: a requester raises req_valid[i] with req_data slice i stable and
// holds both until req_valid[i] & req_ready[i] is seen high at a rising clock
// edge; that edge is the transfer. req_ready is one-hot, only in S_IDLE.
module counter_sched
    import counter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       done,
    output logic                   aborted,
    input  logic                   abort,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   err_no_ovf,
    output logic                   cnt_enable,
    output logic                   cnt_load,
    output logic [WIDTH-1:0]       cnt_load_data,
    input  logic [WIDTH-1:0]       cnt_count,
    input  logic                   cnt_overflow,
    output sched_state_e           state_dbg
);

    sched_state_e      state, state_n;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  l_q;
    logic [ID_W-1:0]   grant_id_q;
    logic              aborted_q;
    logic              err_q;
    logic              accept;
    logic              abort_live;

    assign accept     = (state == S_IDLE) && (|req_valid);
    assign abort_live = abort && ((state == S_LOAD) || (state == S_RUN));

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Select the winning requester's start value.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state and state-decoded outputs; abort gates load/enable in its own cycle.
    always_comb begin
        state_n    = state;
        req_ready  = '0;
        done       = '0;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                // rst_n keeps ready low while reset is held.
                if (rst_n) req_ready = gnt;
                if (|req_valid) state_n = S_LOAD;
            end
            S_LOAD: begin
                cnt_load = !abort;
                state_n  = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                cnt_enable = !abort;
                if (abort)                              state_n = S_IDLE;
                else if (cnt_count == {WIDTH{1'b1}})    state_n = S_DONE;
            end
            S_DONE: begin
                done[grant_id_q] = 1'b1;
                state_n          = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Capture start value and grant index on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q        <= '0;
            grant_id_q <= '0;
        end else if (accept) begin
            l_q        <= sel_data;
            grant_id_q <= gnt_idx;
        end
    end

    // Abort pulse and sticky missing-overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            aborted_q <= abort_live;
            err_q     <= err_q | ((state == S_DONE) && !cnt_overflow);
        end
    end

    assign aborted       = aborted_q;
    assign err_no_ovf    = err_q;
    assign grant_id      = grant_id_q;
    assign cnt_load_data = l_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: table vectors, hand sequences for reset, abort
// and overflow corners, and random traffic against a timeline model.
module tb_counter_sched;
    import counter_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           aborted;
    logic           abort;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err_no_ovf;
    logic           cnt_enable;
    logic           cnt_load;
    logic [W-1:0]   cnt_load_data;
    logic [W-1:0]   cnt_count;
    logic           cnt_overflow;
    sched_state_e   state_dbg;
    logic           withhold;

    counter_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .done(done), .aborted(aborted), .abort(abort),
        .busy(busy), .grant_id(grant_id), .err_no_ovf(err_no_ovf),
        .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_load_data(cnt_load_data),
        .cnt_count(cnt_count), .cnt_overflow(cnt_overflow), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter behind the scheduler; withhold suppresses its overflow pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_count    <= '0;
            cnt_overflow <= 1'b0;
        end else begin
            cnt_overflow <= 1'b0;
            if (cnt_load) cnt_count <= cnt_load_data;
            else if (cnt_enable) begin
                cnt_count <= cnt_count + 1'b1;
                if (cnt_count == 8'hFF && !withhold) cnt_overflow <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Timeline model: a grant at cycle T with start L completes at T+2+(256-L).
    int          m_ptr, m_g, m_t, m_done_at, m_end, m_abort_at;
    bit          m_active;
    logic [W-1:0] m_l;
    logic        m_err;

    // Events seen on the DUT pins, used by the drivers and table checks.
    logic [N-1:0] hs_mask;
    int hs_cnt = 0, done_cnt = 0, ab_cnt = 0;
    int ev_hs_cyc, ev_hs_idx, ev_done_cyc, ev_ab_cyc;

    always @(negedge clk) begin : monitor
        int           g;
        bit           busy_e, abort_now, exp_ab;
        logic         exp_load, exp_en;
        logic [N-1:0] exp_ready, exp_done, m;
        logic [22:0]  exp_vec, act_vec;
        if (!rst_n) begin
            hs_mask    = '0;
            m_ptr      = 0;
            m_g        = 0;
            m_l        = '0;
            m_active   = 1'b0;
            m_abort_at = -10;
            m_err      = 1'b0;
            exp_q.delete();
        end else begin
            busy_e    = m_active && (cyc > m_t) && (cyc <= m_end);
            abort_now = abort && busy_e && (cyc < m_done_at);
            exp_load  = busy_e && (cyc == m_t + 1) && !abort_now;
            exp_en    = busy_e && (cyc >= m_t + 2) && (cyc < m_done_at) && !abort_now;
            exp_done  = (busy_e && cyc == m_done_at) ? onehot(m_g) : '0;
            exp_ab    = (cyc == m_abort_at + 1);
            g         = (!busy_e && req_valid != '0) ? pick(req_valid, m_ptr) : -1;
            exp_ready = (g >= 0) ? onehot(g) : '0;
            exp_vec = {exp_ready, exp_done, exp_ab, busy_e, exp_load, exp_en, 2'(m_g), m_l, m_err};
            act_vec = {req_ready, done, aborted, busy, cnt_load, cnt_enable, grant_id, cnt_load_data, err_no_ovf};
            check("cycle_outputs", 64'(act_vec), 64'(exp_vec));
            if (exp_done != '0) check("count_zero_at_done", 64'(cnt_count), 64'd0);
            if (done != '0) begin
                if (exp_q.size() == 0) check("done_unexpected", 64'(done), 64'd0);
                else                   check("done_scoreboard", 64'(done), 64'(exp_q.pop_front()));
            end
            // pin events
            m = req_ready & req_valid;
            hs_mask = m;
            if (m != '0) begin
                hs_cnt++;
                ev_hs_cyc = cyc;
                for (int i = 0; i < N; i++) if (m[i]) ev_hs_idx = i;
            end
            if (done != '0) begin done_cnt++; ev_done_cyc = cyc; end
            if (aborted)    begin ab_cnt++;   ev_ab_cyc   = cyc; end
            // model advance
            if (abort_now) begin
                m_end      = cyc;
                m_abort_at = cyc;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            if (exp_done != '0 && withhold) m_err = 1'b1;
            if (g >= 0) begin
                m_t       = cyc;
                m_g       = g;
                m_l       = req_data[g*W +: W];
                m_ptr     = (g + 1) % N;
                m_done_at = cyc + 2 + (256 - int'(m_l));
                m_end     = m_done_at;
                m_active  = 1'b1;
                exp_q.push_back(onehot(g));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs_mask;
    endtask

    task automatic wait_hs(input int start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (hs_cnt > start) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_end(input int d0, input int a0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > d0 || ab_cnt > a0) begin ok = 1'b1; return; end
            step();
        end
    endtask

    task automatic drain(input int tail);
        for (int i = 0; i < 3000 && req_valid != '0; i++) step();
        check("drain_valids", 64'(req_valid), 64'd0);
        repeat (tail) step();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({req_ready, done, aborted, busy, grant_id, err_no_ovf,
                         cnt_enable, cnt_load, cnt_load_data, state_dbg}), 64'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] l;
        int           abort_off;
        int           exp_grant;
        int           exp_lat;
        bit           exp_done;
    } vec_t;

    vec_t tab[10];

    initial begin : main
        bit ok;
        int n0, d0, a0, hs_c, got;
        int rr_exp[5];
        int rr_n;

        tab[0] = '{4'b0001, 8'd250, -1, 0,   8, 1'b1};
        tab[1] = '{4'b0001, 8'hFF,  -1, 0,   3, 1'b1};
        tab[2] = '{4'b0010, 8'h00,  -1, 1, 258, 1'b1};
        tab[3] = '{4'b0100, 8'h01,  -1, 2, 257, 1'b1};
        tab[4] = '{4'b1000, 8'd128, -1, 3, 130, 1'b1};
        tab[5] = '{4'b1000, 8'hFE,  -1, 3,   4, 1'b1};
        tab[6] = '{4'b0001, 8'd100,  1, 0,   2, 1'b0};
        tab[7] = '{4'b0100, 8'hFF,   2, 2,   3, 1'b0};
        tab[8] = '{4'b0010, 8'hFF,   3, 1,   3, 1'b1};
        tab[9] = '{4'b0010, 8'd200,  4, 1,   5, 1'b0};
        rr_exp = '{0, 1, 2, 3, 0};

        req_valid = '0;
        req_data  = '0;
        abort     = 1'b0;
        withhold  = 1'b0;
        rst_n     = 1'b0;

        // reset state
        step();
        check_reset_outputs("reset_state");
        step();
        rst_n = 1'b1;
        step();

        // round robin with all requesters continuously valid
        req_data = {N{8'hFF}};
        rr_n = 0;
        n0 = hs_cnt;
        req_valid = 4'hF;
        for (int i = 0; i < 200 && rr_n < 5; i++) begin
            step();
            if (hs_cnt > n0) begin
                n0 = hs_cnt;
                check("rr_grant", 64'(ev_hs_idx), 64'(rr_exp[rr_n]));
                rr_n++;
                if (rr_n < 5) req_valid = 4'hF;
            end
        end
        check("rr_count", 64'(rr_n), 64'd5);
        drain(8);

        // table vectors
        for (int t = 0; t < 10; t++) begin
            n0 = hs_cnt; d0 = done_cnt; a0 = ab_cnt;
            req_data  = {N{tab[t].l}};
            req_valid = tab[t].valid;
            wait_hs(n0, ok);
            if (!ok) begin check("tab_hs_timeout", 64'd0, 64'd1); req_valid = '0; continue; end
            hs_c = ev_hs_cyc;
            check("tab_grant", 64'(ev_hs_idx), 64'(tab[t].exp_grant));
            if (tab[t].abort_off >= 1) begin
                repeat (tab[t].abort_off - 1) step();
                abort = 1'b1;
                step();
                abort = 1'b0;
            end
            wait_end(d0, a0, ok);
            if (!ok) begin check("tab_end_timeout", 64'd0, 64'd1); continue; end
            got = (done_cnt > d0) ? 1 : 0;
            check("tab_done_seen", 64'(got), 64'(tab[t].exp_done));
            check("tab_latency", 64'((got == 1 ? ev_done_cyc : ev_ab_cyc) - hs_c), 64'(tab[t].exp_lat));
            repeat (3) step();
        end

        // after aborting requester 1, the pointer sits at 2
        req_data = {N{8'hFF}};
        n0 = hs_cnt;
        req_valid = 4'b0101;
        wait_hs(n0, ok);
        check("post_abort_grant", 64'(ev_hs_idx), ok ? 64'd2 : 64'hDEAD);
        n0 = hs_cnt;
        wait_hs(n0, ok);
        check("post_abort_grant2", 64'(ev_hs_idx), ok ? 64'd0 : 64'hDEAD);
        drain(8);

        // asynchronous reset in the middle of RUN
        req_data[0*W +: W] = 8'd10;
        n0 = hs_cnt;
        req_valid = 4'b0001;
        wait_hs(n0, ok);
        repeat (3) step();
        check("pre_reset_enable", 64'(cnt_enable), 64'd1);
        #2;
        rst_n = 1'b0;
        req_data[1*W +: W] = 8'hFF;
        req_data[2*W +: W] = 8'hFF;
        req_valid = 4'b0110;
        #1;
        check_reset_outputs("async_reset_outputs");
        step();
        check_reset_outputs("reset_held_outputs");
        step();
        rst_n = 1'b1;
        n0 = hs_cnt;
        wait_hs(n0, ok);
        check("after_reset_grant", 64'(ev_hs_idx), ok ? 64'd1 : 64'hDEAD);
        n0 = hs_cnt;
        wait_hs(n0, ok);
        check("after_reset_grant2", 64'(ev_hs_idx), ok ? 64'd2 : 64'hDEAD);
        drain(8);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(0, 7) == 0) begin
                    req_data[r*W +: W] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                                      : 8'($urandom_range(224, 255));
                    req_valid[r] = 1'b1;
                end
            end
            abort = ($urandom_range(0, 29) == 0);
        end
        abort = 1'b0;
        drain(270);

        // overflow withheld: err_no_ovf sets and stays
        check("err_clear_normal", 64'(err_no_ovf), 64'd0);
        withhold = 1'b1;
        req_data[3*W +: W] = 8'hFE;
        n0 = hs_cnt; d0 = done_cnt;
        req_valid = 4'b1000;
        wait_hs(n0, ok);
        wait_end(d0, ab_cnt, ok);
        step();
        check("err_set", 64'(err_no_ovf), 64'd1);
        withhold = 1'b0;
        req_data[0*W +: W] = 8'hFF;
        n0 = hs_cnt; d0 = done_cnt;
        req_valid = 4'b0001;
        wait_hs(n0, ok);
        wait_end(d0, ab_cnt, ok);
        repeat (10) step();
        check("err_sticky", 64'(err_no_ovf), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
